fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV64 pipeline, directly upstream of decode.
- Holds the PC and issues word requests to instruction memory over a req/ready + rvalid handshake, with at most one request outstanding.
- Drives the IF/ID register (inst, pc_out, inst_valid) consumed by decode.
- Honours the hazard-unit stall and the branch-redirect flush; a one-entry skid buffer prevents response loss while decode is stalled.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
NOP_INST, 32'h00000013, instruction driven on inst when the slot is empty (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
stall  input  1  decode hold; IF/ID register must not change.
flush  input  1  taken-branch redirect from execute.
branch_target  input  64  redirect PC; bits[1:0] ignored (forced 0).
imem_req  output  1  request valid.
imem_addr  output  64  request word address (= pc).
imem_ready  input  1  memory accepts request this cycle when imem_req=1.
imem_rvalid  input  1  response valid; earliest one cycle after accept.
imem_rdata  input  32  response instruction word.
inst  output  32  IF/ID instruction to decode.
pc_out  output  64  IF/ID PC of inst.
inst_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (reset=0, async) values: state=S_IDLE, pc=RESET_PC, inst=NOP_INST, pc_out=0, inst_valid=0, skid empty, imem_req=0.
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN.
- S_IDLE: imem_req=0; go to S_REQ unconditionally on the next edge. First request is one cycle after reset release.
- S_REQ:
  - imem_req = !flush; imem_addr = pc.
  - On imem_ready & !flush: fetch_pc <= pc, pc <= pc+4 (64-bit modulo, wraps at 2^64), go to S_WAIT.
- S_WAIT: imem_req=0. On imem_rvalid & !flush:
  - Slot free (!inst_valid | !stall): inst <= imem_rdata, pc_out <= fetch_pc, inst_valid <= 1, go to S_REQ.
  - Slot busy (inst_valid & stall): skid <= {imem_rdata, fetch_pc}, go to S_HOLD.
- S_HOLD: imem_req=0. On !stall: skid moves into IF/ID (inst_valid=1), skid cleared, go to S_REQ.
- S_DRAIN: imem_req=0. On imem_rvalid: response discarded, go to S_REQ.
- Slot consumed with no new data (!stall, no load this cycle): inst_valid <= 0, inst <= NOP_INST; pc_out holds.
- stall=1 (no flush): inst, pc_out, inst_valid frozen. pc advances only via S_REQ accepts.
- flush (highest priority, overrides stall and every state):
  - pc <= {branch_target[63:2],2'b00}.
  - inst_valid <= 0, inst <= NOP_INST, skid cleared.
  - Next state:
    - From S_WAIT without rvalid in the same cycle: S_DRAIN.
    - From S_WAIT with rvalid in the same cycle: the response is dropped; S_REQ.
    - From S_DRAIN without rvalid: remain in S_DRAIN.
    - All other cases: S_REQ.
  - imem_req is forced to 0 in the flush cycle.
- Peak throughput: one instruction per 2 cycles with a 1-cycle-latency memory.
- Reset asserted mid-transaction: all state returns to reset values immediately. Any outstanding memory response is the memory's responsibility; memory is reset by the same signal.

Test Plan:
- Reset: hold reset=0 for 3 cycles with RESET_PC=0x1000, then release -> imem_req=0 in cycle 0, =1 in cycle 1 with imem_addr=0x1000; inst=0x00000013, inst_valid=0 throughout reset.
- Streaming, memory always ready with 1-cycle rvalid, rdata = {0x00A00093, 0x00B00113, 0x002081B3} -> IF/ID shows these words with pc_out = 0x1000, 0x1004, 0x1008, inst_valid high every other cycle.
- Stall with skid: raise stall while IF/ID holds 0x00A00093 and a response 0x00B00113 returns -> IF/ID unchanged, imem_req=0 while in S_HOLD. Drop stall -> 0x00B00113 appears next edge with pc_out=0x1004, then a request for 0x1008.
- Flush during S_WAIT: flush=1, branch_target=0x2003; rvalid with 0xDEADBEEF arrives 2 cycles later -> word discarded (inst_valid=0 throughout), next imem_addr=0x2000.
- Simultaneous flush+stall with inst_valid=1 -> inst_valid=0, inst=NOP next edge, pc=branch_target. Simultaneous flush+rvalid in S_WAIT -> response dropped, S_REQ next.
- PC wrap: RESET_PC=0xFFFF_FFFF_FFFF_FFFC, one fetch accepted -> next imem_addr=0x0. Async reset asserted mid-S_WAIT (between clock edges) -> outputs take reset values before the next clock edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request may be outstanding; the fetch side owns req/addr, memory owns
// ready/rvalid/rdata.
interface fetch_stage_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// RV64 instruction-fetch stage: owns the PC, issues one word request at a
// time to instruction memory and fills the IF/ID register read by decode.
// A one-entry skid buffer parks a response that returns while decode is
// stalled on a valid instruction; a branch flush squashes everything in
// flight, including a response still owed by memory (drained in S_DRAIN).
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [63:0]          branch_target,
    fetch_stage_if.master        imem,
    output logic [31:0]          inst,
    output logic [63:0]          pc_out,
    output logic                 inst_valid
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state, state_nxt;
    logic [63:0] pc;
    logic [63:0] fetch_pc;
    logic [63:0] skid_pc;
    logic [31:0] skid_inst;
    logic        skid_vld;
    logic [63:0] redirect_pc;
    logic        req_c;
    logic        accept;
    logic        rsp_load;
    logic        rsp_skid;
    logic        skid_load;

    assign redirect_pc    = branch_target & ~64'h3;
    assign imem.imem_req  = req_c;
    assign imem.imem_addr = pc;

    // Next-state and per-cycle action decode; flush overrides every state.
    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        accept    = 1'b0;
        rsp_load  = 1'b0;
        rsp_skid  = 1'b0;
        skid_load = 1'b0;
        if (flush) begin
            if ((state == S_WAIT || state == S_DRAIN) && !imem.imem_rvalid)
                state_nxt = S_DRAIN;
            else
                state_nxt = S_REQ;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_REQ;
                S_REQ: begin
                    req_c = 1'b1;
                    if (imem.imem_ready) begin
                        accept    = 1'b1;
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (!inst_valid || !stall) begin
                            rsp_load  = 1'b1;
                            state_nxt = S_REQ;
                        end else begin
                            rsp_skid  = 1'b1;
                            state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        skid_load = skid_vld;
                        state_nxt = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem.imem_rvalid)
                        state_nxt = S_REQ;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // PC advances on an accepted request; a flush redirects it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            fetch_pc <= 64'h0;
        end else if (flush) begin
            pc <= redirect_pc;
        end else if (accept) begin
            fetch_pc <= pc;
            pc       <= pc + 64'd4;
        end
    end

    // Skid buffer: captures a response that arrives while IF/ID is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_vld  <= 1'b0;
            skid_inst <= NOP_INST;
            skid_pc   <= 64'h0;
        end else if (flush || skid_load) begin
            skid_vld <= 1'b0;
        end else if (rsp_skid) begin
            skid_vld  <= 1'b1;
            skid_inst <= imem.imem_rdata;
            skid_pc   <= fetch_pc;
        end
    end

    // IF/ID register: load new work, or retire the consumed slot to a NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst       <= NOP_INST;
            pc_out     <= 64'h0;
            inst_valid <= 1'b0;
        end else if (flush) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
        end else if (rsp_load) begin
            inst       <= imem.imem_rdata;
            pc_out     <= fetch_pc;
            inst_valid <= 1'b1;
        end else if (skid_load) begin
            inst       <= skid_inst;
            pc_out     <= skid_pc;
            inst_valid <= 1'b1;
        end else if (!stall) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. A behavioural memory answers requests after a
// chosen or random latency; the reference model keeps the fetched-but-not-yet-
// consumed instructions in an ordered queue (at most IF/ID plus one parked
// entry), clears it on a flush, and predicts the next fetch address from the
// redirect/increment rule. A second instance starts at the top of the address
// space to observe PC wrap-around.
module tb_fetch_stage;
    localparam logic [63:0] RST_PC  = 64'h1000;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct {
        logic [31:0] w;
        logic [63:0] a;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [31:0] inst;
    logic [63:0] pc_out;
    logic        inst_valid;
    logic [31:0] w_inst;
    logic [63:0] w_pc_out;
    logic        w_valid;

    fetch_stage_if bus();
    fetch_stage_if w_bus();

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_target(branch_target), .imem(bus),
        .inst(inst), .pc_out(pc_out), .inst_valid(inst_valid)
    );

    fetch_stage #(.RESET_PC(WRAP_PC), .NOP_INST(NOP)) dut_wrap (
        .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0),
        .branch_target(64'h0), .imem(w_bus),
        .inst(w_inst), .pc_out(w_pc_out), .inst_valid(w_valid)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    ent_t        q[$];
    logic [63:0] exp_pc;
    logic [63:0] last_pc;
    logic        mem_busy;
    logic        mem_sq;
    int          mem_cnt;
    logic [63:0] mem_addr;
    logic [31:0] mem_w;
    int          lat_fix = 1;
    logic        rdy_rand = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_w = 32'h0;
    logic        last_req;
    logic [63:0] last_addr;
    logic        w_pend;
    logic [63:0] w_addrs[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h1000: return 32'h00A0_0093;
            64'h1004: return 32'h00B0_0113;
            64'h1008: return 32'h0020_81B3;
            default:  return a[31:0] ^ a[63:32] ^ 32'h3C5A_9E17;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        exp_pc   = RST_PC;
        last_pc  = 64'h0;
        mem_busy = 1'b0;
        mem_sq   = 1'b0;
        mem_cnt  = 0;
        w_pend   = 1'b0;
    endtask

    // Holds reset for the given number of clock edges, then releases it
    // between edges so the next tick observes cycle 0 after release.
    task automatic do_reset(input int cycles);
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        bus.imem_ready    = 1'b0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = 32'h0;
        w_bus.imem_ready  = 1'b1;
        w_bus.imem_rvalid = 1'b0;
        w_bus.imem_rdata  = 32'h0010_0073;
        model_reset();
        repeat (cycles) begin
            @(posedge clk);
            #1;
            chk("rst_inst", 64'(inst), 64'(NOP));
            chk("rst_valid", 64'(inst_valid), 64'(1'b0));
            chk("rst_pc_out", pc_out, 64'h0);
            chk("rst_req", 64'(bus.imem_req), 64'(1'b0));
        end
        #1 reset = 1'b1;
    endtask

    // One clock cycle: drive inputs and memory at the falling edge, observe
    // the request, advance the reference model at the rising edge, compare.
    task automatic tick(input logic st, input logic fl, input logic [63:0] tgt);
        logic        req, rv, rdy, w_req, ev;
        logic [63:0] addr, w_addr, ep;
        logic [31:0] ei;
        int          qn;
        ent_t        e;
        @(negedge clk);
        stall = st;
        flush = fl;
        branch_target = tgt;
        rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        rv  = mem_busy && (mem_cnt == 0);
        bus.imem_ready  = rdy;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? mem_w : $urandom;
        w_bus.imem_rvalid = w_pend;
        #1;
        req    = bus.imem_req;
        addr   = bus.imem_addr;
        w_req  = w_bus.imem_req;
        w_addr = w_bus.imem_addr;
        last_req  = req;
        last_addr = addr;
        if (fl) chk("req_in_flush", 64'(req), 64'(1'b0));
        if (mem_busy) chk("one_outstanding", 64'(req), 64'(1'b0));
        if (q.size() == 2) chk("req_while_parked", 64'(req), 64'(1'b0));
        qn = q.size();
        @(posedge clk);
        #1;
        if (w_req) w_addrs.push_back(w_addr);
        w_pend = w_req;
        if (fl) begin
            q.delete();
            exp_pc = tgt & ~64'h3;
            if (mem_busy) mem_sq = 1'b1;
        end else if (qn > 0 && !st) begin
            void'(q.pop_front());
        end
        if (rv) begin
            if (!mem_sq) begin
                e.w = mem_w;
                e.a = mem_addr;
                q.push_back(e);
            end
            mem_sq   = 1'b0;
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (req && rdy) begin
            chk("fetch_addr", addr, exp_pc);
            exp_pc   = exp_pc + 64'd4;
            mem_busy = 1'b1;
            mem_addr = addr;
            mem_w    = ovr_en ? ovr_w : mem_word(addr);
            mem_cnt  = ((lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3))) - 1;
        end
        if (q.size() > 0) begin
            ev = 1'b1; ei = q[0].w; ep = q[0].a;
        end else begin
            ev = 1'b0; ei = NOP; ep = last_pc;
        end
        last_pc = ep;
        chk("inst_valid", 64'(inst_valid), 64'(ev));
        chk("inst", 64'(inst), 64'(ei));
        chk("pc_out", pc_out, ep);
    endtask

    initial begin
        // Reset and first request timing, then streaming at one per 2 cycles.
        do_reset(3);
        tick(1'b0, 1'b0, 64'h0);
        chk("c0_req", 64'(last_req), 64'(1'b0));
        tick(1'b0, 1'b0, 64'h0);
        chk("c1_req", 64'(last_req), 64'(1'b1));
        chk("c1_addr", last_addr, 64'h1000);
        tick(1'b0, 1'b0, 64'h0);
        chk("stream0_inst", 64'(inst), 64'h00A0_0093);
        chk("stream0_pc", pc_out, 64'h1000);
        tick(1'b0, 1'b0, 64'h0);
        chk("stream_gap_valid", 64'(inst_valid), 64'(1'b0));
        tick(1'b0, 1'b0, 64'h0);
        chk("stream1_inst", 64'(inst), 64'h00B0_0113);
        chk("stream1_pc", pc_out, 64'h1004);
        tick(1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 64'h0);
        chk("stream2_inst", 64'(inst), 64'h0020_81B3);
        chk("stream2_pc", pc_out, 64'h1008);
        chk("wrap_seen", 64'(w_addrs.size() >= 2), 64'(1'b1));
        if (w_addrs.size() >= 2) begin
            chk("wrap_first_addr", w_addrs[0], WRAP_PC);
            chk("wrap_next_addr", w_addrs[1], 64'h0);
        end

        // Stall with a response returning into the skid buffer.
        do_reset(2);
        tick(1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 64'h0);
        tick(1'b1, 1'b0, 64'h0);
        tick(1'b1, 1'b0, 64'h0);
        chk("skid_hold_inst", 64'(inst), 64'h00A0_0093);
        tick(1'b1, 1'b0, 64'h0);
        chk("hold_req", 64'(last_req), 64'(1'b0));
        chk("hold_pc_out", pc_out, 64'h1000);
        tick(1'b0, 1'b0, 64'h0);
        chk("unskid_inst", 64'(inst), 64'h00B0_0113);
        chk("unskid_pc", pc_out, 64'h1004);
        lat_fix = 3;
        ovr_en  = 1'b1;
        ovr_w   = 32'hDEAD_BEEF;
        tick(1'b0, 1'b0, 64'h0);
        chk("after_skid_addr", last_addr, 64'h1008);
        ovr_en = 1'b0;

        // Flush in S_WAIT: late response is drained, fetch resumes at target.
        tick(1'b0, 1'b1, 64'h2003);
        tick(1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 64'h0);
        chk("drain_valid", 64'(inst_valid), 64'(1'b0));
        lat_fix = 1;
        tick(1'b0, 1'b0, 64'h0);
        chk("redirect_req", 64'(last_req), 64'(1'b1));
        chk("redirect_addr", last_addr, 64'h2000);
        tick(1'b0, 1'b0, 64'h0);

        // Flush together with stall, then flush together with rvalid.
        tick(1'b1, 1'b1, 64'h3000);
        chk("flush_stall_valid", 64'(inst_valid), 64'(1'b0));
        chk("flush_stall_inst", 64'(inst), 64'(NOP));
        tick(1'b0, 1'b0, 64'h0);
        chk("flush_stall_addr", last_addr, 64'h3000);
        tick(1'b0, 1'b1, 64'h4000);
        tick(1'b0, 1'b0, 64'h0);
        chk("flush_rvalid_req", 64'(last_req), 64'(1'b1));
        chk("flush_rvalid_addr", last_addr, 64'h4000);

        // Asynchronous reset between edges while a fetch is outstanding.
        tick(1'b0, 1'b0, 64'h0);
        lat_fix = 3;
        tick(1'b1, 1'b0, 64'h0);
        tick(1'b1, 1'b0, 64'h0);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 64'(inst_valid), 64'(1'b0));
        chk("async_inst", 64'(inst), 64'(NOP));
        chk("async_pc_out", pc_out, 64'h0);
        chk("async_req", 64'(bus.imem_req), 64'(1'b0));
        do_reset(2);

        // Randomised traffic against the queue model.
        lat_fix  = 0;
        rdy_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic        st, fl;
            logic [63:0] tgt;
            st = ($urandom_range(0, 99) < 30);
            fl = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0)
                tgt = {60'hFFF_FFFF_FFFF_FFFF, 4'($urandom_range(0, 15))};
            else
                tgt = {$urandom, $urandom};
            tick(st, fl, tgt);
            if (i == 1500) begin
                #2 reset = 1'b0;
                do_reset(2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
